// File: rtl/tag_array.sv
// Marker package for the tag array file set; declares a single constant and nothing else.
package tag_array_marker_pkg;
    localparam int MARKER = 0;
endpackage

// File: rtl/tag_array_pkg.sv
// Shared widths, SRAM entry layout, controller states and address field helpers for the tag array.
package tag_array_pkg;
    localparam int ADDR_WIDTH  = 32;
    localparam int INDEX_BITS  = 6;
    localparam int OFFSET_BITS = 3;
    localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int WAY_BITS    = TAG_BITS + 1;
    localparam int NUM_SETS    = 1 << INDEX_BITS;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
    } way_entry_t;

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

    function automatic logic [INDEX_BITS-1:0] get_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    endfunction

    function automatic logic [TAG_BITS-1:0] get_tag(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS];
    endfunction
endpackage

// File: rtl/tag_array_ctrl_if.sv
// Cache-pipeline lookup/fill handshakes plus the 1RW tag SRAM pins; master = pipeline and macro, slave = controller.
interface tag_array_ctrl_if;
    import tag_array_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_hit;
    logic                  resp_way;
    logic                  resp_victim_way;
    logic                  fill_valid;
    logic                  fill_ready;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic                  fill_way;
    logic                  init_done;
    logic                  sram_csb0;
    logic                  sram_web0_aL;
    logic [1:0]            sram_wmask0;
    logic [INDEX_BITS-1:0] sram_addr0;
    logic [2*WAY_BITS-1:0] sram_din0;
    logic [2*WAY_BITS-1:0] sram_dout0;

    modport master (
        output req_valid, req_addr, resp_ready, fill_valid, fill_addr, fill_way, sram_dout0,
        input  req_ready, resp_valid, resp_hit, resp_way, resp_victim_way, fill_ready, init_done,
               sram_csb0, sram_web0_aL, sram_wmask0, sram_addr0, sram_din0
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, fill_valid, fill_addr, fill_way, sram_dout0,
        output req_ready, resp_valid, resp_hit, resp_way, resp_victim_way, fill_ready, init_done,
               sram_csb0, sram_web0_aL, sram_wmask0, sram_addr0, sram_din0
    );
endinterface

// File: rtl/tag_way_compare.sv
// Splits a 2-way SRAM line into entries and reports per-way valid and tag match; purely combinational.
module tag_way_compare
    import tag_array_pkg::*;
(
    input  logic [2*WAY_BITS-1:0] i_line,
    input  logic [TAG_BITS-1:0]   i_tag,
    output logic [1:0]            o_hit,
    output logic [1:0]            o_valid
);
    for (genvar w = 0; w < 2; w++) begin : g_way
        way_entry_t w_ent;
        assign w_ent      = i_line[w*WAY_BITS +: WAY_BITS];
        assign o_valid[w] = w_ent.valid;
        assign o_hit[w]   = w_ent.valid && (w_ent.tag == i_tag);
    end
endmodule

// File: rtl/tag_array_ctrl.sv
// Tag SRAM initiator: clears all sets after reset, serves lookups with hit/way/LRU victim, writes fills (fill wins).
// Result valid two cycles after accept and held until resp_ready; no lookup or fill is taken while a result is pending.
module tag_array_ctrl
    import tag_array_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    tag_array_ctrl_if.slave bus
);
    state_t                r_state;
    logic [INDEX_BITS-1:0] r_cnt;
    logic [INDEX_BITS-1:0] r_idx;
    logic [TAG_BITS-1:0]   r_tag;
    logic [NUM_SETS-1:0]   r_lru;
    logic                  r_resp_valid;
    logic                  r_resp_hit;
    logic                  r_resp_way;
    logic                  r_resp_victim;
    logic                  r_init_done;

    logic                  w_fill_go;
    logic                  w_req_go;
    logic [INDEX_BITS-1:0] w_fill_idx;
    logic [INDEX_BITS-1:0] w_req_idx;
    way_entry_t            w_fill_ent;
    logic [1:0]            w_hit;
    logic [1:0]            w_valid;
    logic                  w_hit_way;
    logic                  w_victim;

    assign w_fill_go  = (r_state == IDLE) && bus.fill_valid;
    assign w_req_go   = (r_state == IDLE) && !bus.fill_valid && bus.req_valid;
    assign w_fill_idx = get_index(bus.fill_addr);
    assign w_req_idx  = get_index(bus.req_addr);
    assign w_fill_ent = '{valid: 1'b1, tag: get_tag(bus.fill_addr)};

    tag_way_compare u_cmp (
        .i_line  (bus.sram_dout0),
        .i_tag   (r_tag),
        .o_hit   (w_hit),
        .o_valid (w_valid)
    );

    // A double hit resolves to way 0; victim prefers an empty way before consulting LRU.
    assign w_hit_way = !w_hit[0] && w_hit[1];
    assign w_victim  = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[r_idx]);

    always_comb begin
        bus.sram_csb0    = 1'b1;
        bus.sram_web0_aL = 1'b1;
        bus.sram_wmask0  = '0;
        bus.sram_addr0   = '0;
        bus.sram_din0    = '0;
        if (!rst && r_state == INIT) begin
            bus.sram_csb0    = 1'b0;
            bus.sram_web0_aL = 1'b0;
            bus.sram_wmask0  = 2'b11;
            bus.sram_addr0   = r_cnt;
        end else if (w_fill_go) begin
            bus.sram_csb0    = 1'b0;
            bus.sram_web0_aL = 1'b0;
            bus.sram_wmask0  = bus.fill_way ? 2'b10 : 2'b01;
            bus.sram_addr0   = w_fill_idx;
            bus.sram_din0    = {w_fill_ent, w_fill_ent};
        end else if (w_req_go) begin
            bus.sram_csb0    = 1'b0;
            bus.sram_addr0   = w_req_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= INIT;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_tag         <= '0;
            r_lru         <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_hit    <= 1'b0;
            r_resp_way    <= 1'b0;
            r_resp_victim <= 1'b0;
            r_init_done   <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + INDEX_BITS'(1);
                    if (&r_cnt) begin
                        r_state     <= IDLE;
                        r_init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (w_fill_go) begin
                        r_lru[w_fill_idx] <= ~bus.fill_way;
                    end else if (w_req_go) begin
                        r_idx   <= w_req_idx;
                        r_tag   <= get_tag(bus.req_addr);
                        r_state <= WAIT;
                    end
                end
                // Read data is only valid at this edge; it goes undefined right after.
                WAIT: begin
                    r_resp_hit    <= |w_hit;
                    r_resp_way    <= w_hit_way;
                    r_resp_victim <= w_victim;
                    r_resp_valid  <= 1'b1;
                    if (|w_hit) begin
                        r_lru[r_idx] <= ~w_hit_way;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign bus.req_ready       = w_req_go;
    assign bus.fill_ready      = w_fill_go;
    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_hit        = r_resp_hit;
    assign bus.resp_way        = r_resp_way;
    assign bus.resp_victim_way = r_resp_victim;
    assign bus.init_done       = r_init_done;
endmodule

// File: tb/tb_tag_array_ctrl.sv
// Randomized bench for tag_array_ctrl with a behavioural SRAM macro and a set/way reference model.
module tb_tag_array_ctrl;
    logic clk = 1'b0;
    logic rst;

    tag_array_ctrl_if bus();

    tag_array_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [47:0] mem   [64];
    logic [1:0]  m_v   [64];
    logic [22:0] m_t   [64][2];
    logic        m_mru [64];
    logic [22:0] pool  [4];

    // Macro behaviour: inputs sampled at posedge, write lands at negedge, read data
    // appears by negedge and turns to garbage 1 ns after the following posedge.
    always begin : sram_model
        logic        cs, we;
        logic [5:0]  a;
        logic [47:0] d;
        logic [1:0]  m;
        @(posedge clk);
        cs = !bus.sram_csb0;
        we = !bus.sram_web0_aL;
        a  = bus.sram_addr0;
        d  = bus.sram_din0;
        m  = bus.sram_wmask0;
        #1 bus.sram_dout0 = 48'({$urandom, $urandom});
        @(negedge clk);
        if (cs && we) begin
            for (int w = 0; w < 2; w++)
                if (m[w]) mem[a][w*24 +: 24] = d[w*24 +: 24];
        end else if (cs) begin
            bus.sram_dout0 = mem[a];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_v[s]   = 2'b00;
            m_mru[s] = 1'b1;
        end
    endtask

    task automatic init_sweep();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("init_wr", {bus.sram_csb0, bus.sram_web0_aL, bus.sram_wmask0, bus.sram_addr0},
                {1'b0, 1'b0, 2'b11, i[5:0]});
            chk("init_din", bus.sram_din0, 0);
            chk("init_rdy", {bus.req_ready, bus.fill_ready, bus.init_done, bus.resp_valid}, 0);
            if (i == 63) begin
                bus.req_valid  = 1'b0;
                bus.fill_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("init_done", {bus.init_done, bus.sram_csb0}, 2'b11);
        @(posedge clk); #1;
    endtask

    task automatic do_fill(input logic [31:0] a, input logic w);
        logic [5:0]  idx;
        logic [22:0] tag;
        idx = a[8:3];
        tag = a[31:9];
        bus.fill_addr  = a;
        bus.fill_way   = w;
        bus.fill_valid = 1'b1;
        @(negedge clk);
        chk("fill_rdy", {bus.fill_ready, bus.req_ready}, 2'b10);
        chk("fill_cmd", {bus.sram_csb0, bus.sram_web0_aL, bus.sram_wmask0, bus.sram_addr0},
            {1'b0, 1'b0, (w ? 2'b10 : 2'b01), idx});
        chk("fill_din", bus.sram_din0, {1'b1, tag, 1'b1, tag});
        @(posedge clk); #1;
        bus.fill_valid = 1'b0;
        m_v[idx][w]   = 1'b1;
        m_t[idx][w]   = tag;
        m_mru[idx]    = w;
    endtask

    task automatic do_lookup(input logic [31:0] a, input int hold);
        logic [5:0]  idx;
        logic [22:0] tag;
        logic        h0, h1, eh, ew, ev;
        int          n;
        idx = a[8:3];
        tag = a[31:9];
        h0  = m_v[idx][0] && (m_t[idx][0] == tag);
        h1  = m_v[idx][1] && (m_t[idx][1] == tag);
        eh  = h0 || h1;
        ew  = !h0 && h1;
        ev  = !m_v[idx][0] ? 1'b0 : (!m_v[idx][1] ? 1'b1 : !m_mru[idx]);
        bus.req_addr  = a;
        bus.req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("req_wait", n, 0);
        chk("rd_cmd", {bus.sram_csb0, bus.sram_web0_aL, bus.sram_wmask0, bus.sram_addr0},
            {1'b0, 1'b1, 2'b00, idx});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("wait_st", {bus.resp_valid, bus.sram_csb0}, 2'b01);
        @(negedge clk);
        chk("resp", {bus.resp_valid, bus.resp_hit, bus.resp_way, bus.resp_victim_way}, {1'b1, eh, ew, ev});
        bus.req_valid  = 1'b1;
        bus.fill_valid = 1'b1;
        #1;
        chk("resp_busy", {bus.req_ready, bus.fill_ready, bus.sram_csb0}, 3'b001);
        bus.req_valid  = 1'b0;
        bus.fill_valid = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            chk("resp_hold", {bus.resp_valid, bus.resp_hit, bus.resp_way, bus.resp_victim_way}, {1'b1, eh, ew, ev});
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("resp_clr", bus.resp_valid, 0);
        if (eh) m_mru[idx] = ew;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, a2;
        logic [5:0]  ridx;
        pool[0] = 23'h000009;
        pool[1] = 23'h004009;
        pool[2] = 23'h008009;
        pool[3] = 23'h2A5A5A;
        for (int s = 0; s < 64; s++) mem[s] = 48'({$urandom, $urandom});
        model_reset();
        bus.sram_dout0 = '0;
        bus.resp_ready = 1'b0;
        bus.fill_way   = 1'b0;
        bus.fill_addr  = 32'h0000_1238;
        bus.req_addr   = 32'h0000_1238;
        bus.req_valid  = 1'b1;
        bus.fill_valid = 1'b1;
        rst = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {bus.resp_valid, bus.resp_hit, bus.resp_way, bus.resp_victim_way,
                        bus.init_done, bus.req_ready, bus.fill_ready}, 0);
        chk("rst_sram", {bus.sram_csb0, bus.sram_web0_aL, bus.sram_wmask0, bus.sram_addr0}, {2'b11, 2'b00, 6'd0});
        chk("rst_din", bus.sram_din0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        init_sweep();

        do_lookup(32'h0000_1238, 0);
        do_fill(32'h0000_1238, 1'b0);
        do_lookup(32'h0000_1238, 0);
        do_fill(32'h0080_1238, 1'b1);
        do_lookup(32'h0080_1238, 1);
        do_lookup(32'h0100_1238, 0);
        chk("victim_lru", bus.resp_victim_way, 0);

        bus.req_addr  = 32'h0100_1238;
        bus.req_valid = 1'b1;
        do_fill(32'h0100_1238, 1'b0);
        do_lookup(32'h0100_1238, 5);

        for (int it = 0; it < 150; it++) begin
            ridx = 6'($urandom_range(5, 9));
            a  = {pool[$urandom_range(0, 3)], ridx, 3'($urandom)};
            a2 = {pool[$urandom_range(0, 3)], ridx, 3'($urandom)};
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.req_addr  = a2;
                    bus.req_valid = 1'b1;
                    do_fill(a, 1'($urandom));
                    do_lookup(a2, $urandom_range(0, 2));
                end else begin
                    do_fill(a, 1'($urandom));
                end
            end else begin
                do_lookup(a, $urandom_range(0, 2));
            end
        end

        bus.req_addr  = 32'h0000_1238;
        bus.req_valid = 1'b1;
        @(negedge clk);
        chk("pre_rst_acc", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_wait", {bus.resp_valid, bus.sram_csb0, bus.init_done}, 3'b010);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        bus.req_valid  = 1'b1;
        bus.fill_valid = 1'b1;
        init_sweep();
        do_lookup(32'h0000_1238, 0);
        do_lookup(32'h0080_1238, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
